// File: rtl/mem_arbiter_ctrl.sv
// Two-requester round-robin arbiter driving an asynchronous SRAM-style memory
// over a shared bidirectional data bus with setup/pulse/hold write timing.
module mem_arbiter_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*AWIDTH-1:0] addr,
  input  logic [2*DWIDTH-1:0] wdata,
  output logic [1:0]          ack,
  output logic [DWIDTH-1:0]   rdata,
  output logic                busy,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic                mem_read,
  output logic                mem_write,
  inout  wire  [DWIDTH-1:0]   mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ASSERT,
    RD_CAPTURE
  } state_t;

  state_t              state_q;
  logic                last_q;
  logic                gnt_q;
  logic                gnt_d;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic [1:0]          ack_q;
  logic                busy_q;
  logic                rd_q;
  logic                wr_q;
  logic                drive_q;

  // Single request wins outright; on contention the one not granted last wins.
  always_comb begin
    gnt_d = req[1];
    if (req == 2'b11) gnt_d = ~last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 2'b00;
          if (req != 2'b00) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            addr_q  <= gnt_d ? addr[2*AWIDTH-1:AWIDTH] : addr[AWIDTH-1:0];
            wdata_q <= gnt_d ? wdata[2*DWIDTH-1:DWIDTH] : wdata[DWIDTH-1:0];
            busy_q  <= 1'b1;
            if (we[gnt_d]) begin
              state_q <= WR_SETUP;
              drive_q <= 1'b1;
            end else begin
              state_q <= RD_ASSERT;
              rd_q    <= 1'b1;
            end
          end
        end
        WR_SETUP: begin
          state_q <= WR_PULSE;
          wr_q    <= 1'b1;
        end
        WR_PULSE: begin
          state_q <= WR_HOLD;
          wr_q    <= 1'b0;
          ack_q   <= gnt_q ? 2'b10 : 2'b01;
        end
        WR_HOLD: begin
          state_q <= IDLE;
          ack_q   <= 2'b00;
          drive_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        // Memory output is sampled while read enable is still high.
        RD_ASSERT: begin
          state_q <= RD_CAPTURE;
          rd_q    <= 1'b0;
          rdata_q <= mem_data;
          ack_q   <= gnt_q ? 2'b10 : 2'b01;
        end
        RD_CAPTURE: begin
          state_q <= IDLE;
          ack_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 2'b00;
          busy_q  <= 1'b0;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_data  = drive_q ? wdata_q : {DWIDTH{1'bz}};

endmodule
